// File: rtl/dmem_store_buf.sv
// Word-wide store FIFO between the CPU store port and the data-memory write port, with load hazard checks.
// Define LD_FORWARD_EN to serve matching loads from the buffer instead of flagging a conflict.
module dmem_store_buf #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_en,
    input  logic [W-1:0] st_addr,
    input  logic [W-1:0] st_data,
    output logic         st_ready,
    input  logic         ld_en,
    input  logic [W-1:0] ld_addr,
    output logic         ld_conflict,
    output logic         ld_hit,
    output logic [W-1:0] ld_data,
    output logic         mem_we,
    output logic [W-1:0] mem_waddr,
    output logic [W-1:0] mem_wdata,
    input  logic         mem_wready,
    output logic         empty
);

    // Handshakes: a transfer happens on a posedge where valid (st_en / mem_we) and
    // ready (st_ready / mem_wready) are both high; valid holds its payload until then.

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [W-1:0]     addr_q [DEPTH];
    logic [W-1:0]     data_q [DEPTH];

    logic             push;
    logic             pop;
    logic [DEPTH-1:0] match;
    logic             unused_lsbs;

    assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready  = (count_q != (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign mem_we    = !empty;
    assign mem_waddr = addr_q[rd_ptr_q];
    assign mem_wdata = data_q[rd_ptr_q];

    assign push = st_en && st_ready;
    assign pop  = mem_we && mem_wready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (push) begin
            wr_ptr_d         = wr_ptr_q + AW'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (pop) begin
            rd_ptr_d         = rd_ptr_q + AW'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage needs no reset; valid_q qualifies every use.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= {st_addr[W-1:2], 2'b00};
            data_q[wr_ptr_q] <= st_data;
        end
    end

    // Only registered entries are compared, so a same-cycle push never matches.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = ld_en && valid_q[i] && (addr_q[i][W-1:2] == ld_addr[W-1:2]);
        end
    end

`ifdef LD_FORWARD_EN
    logic [AW-1:0] idx;
    logic          fwd_hit;
    logic [W-1:0]  fwd_data;

    // Walk backward from the youngest entry so the newest store to a word wins.
    always_comb begin
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = wr_ptr_q - AW'(1) - AW'(k);
            if (!fwd_hit && match[idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign ld_hit      = fwd_hit;
    assign ld_data     = fwd_data;
    assign ld_conflict = 1'b0;
`else
    assign ld_hit      = 1'b0;
    assign ld_data     = '0;
    assign ld_conflict = |match;
`endif

endmodule

// File: tb/tb_dmem_store_buf.sv
// Self-checking bench for dmem_store_buf: directed scenarios plus random traffic against a queue-based model.
module tb_dmem_store_buf;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic         clk;
  logic         rst;
  logic         st_en;
  logic [W-1:0] st_addr;
  logic [W-1:0] st_data;
  logic         st_ready;
  logic         ld_en;
  logic [W-1:0] ld_addr;
  logic         ld_conflict;
  logic         ld_hit;
  logic [W-1:0] ld_data;
  logic         mem_we;
  logic [W-1:0] mem_waddr;
  logic [W-1:0] mem_wdata;
  logic         mem_wready;
  logic         empty;

  dmem_store_buf #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .st_en      (st_en),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_ready   (st_ready),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_conflict(ld_conflict),
    .ld_hit     (ld_hit),
    .ld_data    (ld_data),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wready (mem_wready),
    .empty      (empty)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst        = 1'b1;
    st_en      = 1'b0;
    st_addr    = '0;
    st_data    = '0;
    ld_en      = 1'b0;
    ld_addr    = '0;
    mem_wready = 1'b0;
  end

  // scoreboard: pending stores in program order
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_addr_q[$];
  bit           model_ok = 1'b0;
  int           commits  = 0;
  int           checks   = 0;
  int           errors   = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic r, input logic se, input logic [W-1:0] sa, input logic [W-1:0] sd,
                      input logic le, input logic [W-1:0] la, input logic wr);
    logic         f_hit;
    logic         f_any;
    logic [W-1:0] f_data;
    logic [W-1:0] a;
    logic         do_push;
    logic         do_pop;
    @(negedge clk);
    rst = r; st_en = se; st_addr = sa; st_data = sd;
    ld_en = le; ld_addr = la; mem_wready = wr;
    #1;
    if (model_ok) begin
      f_hit = 1'b0; f_any = 1'b0; f_data = '0;
      if (le) begin
        for (int i = exp_addr_q.size() - 1; i >= 0; i--) begin
          a = exp_addr_q[i];
          if (a[W-1:2] == la[W-1:2]) begin
            f_any = 1'b1;
            if (!f_hit) begin
              f_hit  = 1'b1;
              f_data = exp_q[i];
            end
          end
        end
      end
      check_eq("st_ready", W'(st_ready), W'(exp_q.size() != DEPTH));
      check_eq("empty",    W'(empty),    W'(exp_q.size() == 0));
      check_eq("mem_we",   W'(mem_we),   W'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check_eq("mem_waddr", mem_waddr, exp_addr_q[0]);
        check_eq("mem_wdata", mem_wdata, exp_q[0]);
      end
`ifdef LD_FORWARD_EN
      check_eq("ld_hit",      W'(ld_hit),      W'(f_hit));
      check_eq("ld_data",     ld_data,         f_data);
      check_eq("ld_conflict", W'(ld_conflict), '0);
`else
      check_eq("ld_hit",      W'(ld_hit),      '0);
      check_eq("ld_data",     ld_data,         '0);
      check_eq("ld_conflict", W'(ld_conflict), W'(f_any));
`endif
    end
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_addr_q.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      do_push = se && (exp_q.size() < DEPTH);
      do_pop  = wr && (exp_q.size() > 0);
      if (do_pop) begin
        void'(exp_q.pop_front());
        void'(exp_addr_q.pop_front());
        commits++;
      end
      if (do_push) begin
        exp_q.push_back(sd);
        exp_addr_q.push_back({sa[W-1:2], 2'b00});
      end
    end
  endtask

  task automatic idle(input logic wr, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, wr);
  endtask

  initial begin
    int n;
    int cyc;
    logic accept;

    // reset and single store
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h10, 32'hAAAA, 1'b0, '0, 1'b1);
    idle(1'b1, 3);

    // fill with memory stalled, then hold the fifth store while draining
    step(1'b0, 1'b1, 32'h0,  32'h100, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h4,  32'h104, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h8,  32'h108, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'hC,  32'h10C, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h10, 32'h110, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h10, 32'h110, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'h10, 32'h110, 1'b0, '0, 1'b1);
    idle(1'b1, 6);

    // two stores to one word, then a load to that word
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h20, 32'h1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h20, 32'h2, 1'b1, 32'h20, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 32'h22, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 32'h24, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 32'h22, 1'b1);

    // reset while draining
    step(1'b0, 1'b1, 32'h30, 32'h30, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h34, 32'h34, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h38, 32'h38, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle(1'b1, 3);

    // wrap-around with alternating memory readiness, CPU holds each store until taken
    commits = 0;
    n = 0;
    cyc = 0;
    while ((n < 10 || exp_q.size() != 0) && cyc < 80) begin
      accept = (n < 10) && (exp_q.size() < DEPTH);
      step(1'b0, n < 10, W'(32'h100 + 4 * n), W'(32'hC0DE_0000 + n), 1'b1, W'(32'h100 + 4 * (n % 3)), cyc[0]);
      if (accept) n++;
      cyc++;
    end
    check_eq("wrap_commits", W'(commits), W'(10));

    // random traffic over a small address window so loads hit often
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 1) == 1,
           W'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
           W'($urandom),
           $urandom_range(0, 2) != 0,
           W'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
           $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
